// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide sequencer for the EX stage.
// Works on operand magnitudes for 32 cycles, then applies the sign fix-up when it writes HI/LO.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // opnd: multiplicand or divisor; acc: upper product half or remainder; sr: multiplier or quotient
  logic [WIDTH-1:0] opnd_q, opnd_d, acc_q, acc_d, sr_q, sr_d;
  logic             is_div_q, is_div_d, is_signed_q, is_signed_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  assign mul_sum  = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh   = {acc_q, sr_q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd_q};
  // When the trial succeeds the difference is below the divisor, so WIDTH bits suffice.
  assign div_diff = div_sh[WIDTH-1:0] - opnd_q;

  always_comb begin
    prod = {acc_q, sr_q};
    if (is_signed_q && (sign_a_q ^ sign_b_q)) prod = -prod;
    quot = sr_q;
    if (is_signed_q && (sign_a_q ^ sign_b_q)) quot = -quot;
    rem = acc_q;
    if (is_signed_q && sign_a_q) rem = -rem;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    sr_d        = sr_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          is_div_d    = is_div;
          is_signed_d = is_signed;
          sign_a_d    = is_signed && op_a[WIDTH-1];
          sign_b_d    = is_signed && op_b[WIDTH-1];
          opnd_d      = is_div ? magnitude(op_b, is_signed) : magnitude(op_a, is_signed);
          sr_d        = is_div ? magnitude(op_a, is_signed) : magnitude(op_b, is_signed);
          acc_d       = '0;
          cnt_d       = CNT_LAST;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (is_div_q) begin
          acc_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
          sr_d  = {sr_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          sr_d  = {mul_sum[0], sr_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = is_div_q ? rem  : prod[2*WIDTH-1:WIDTH];
        lo_d    = is_div_q ? quot : prod[WIDTH-1:0];
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush abandons whatever is in flight and must never reach HI/LO.
    if (flush) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    opnd_q      <= opnd_d;
    acc_q       <= acc_d;
    sr_q        <= sr_d;
    is_div_q    <= is_div_d;
    is_signed_q <= is_signed_d;
    sign_a_q    <= sign_a_d;
    sign_b_q    <= sign_b_d;
  end

  assign stall = !flush && ((state_q == S_IDLE && start) || state_q == S_BUSY || state_q == S_DONE);
  assign valid = valid_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: arithmetic/timing model checked every cycle plus literal per-operation results.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn, start, is_div, is_signed, flush;
  logic [31:0] op_a, op_b;
  logic        stall, valid;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // model state: operation in flight, edges left until the write, and architectural HI/LO
  bit          m_busy = 1'b0;
  int          m_left = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_div(is_div), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .valid(valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result as {hi, lo} straight from the arithmetic definition of each instruction.
  function automatic logic [63:0] model(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa, sb, sq, sr;
    logic [31:0] q, r;
    if (!d) begin
      if (s) begin
        sa64 = 64'(signed'(a));
        sb64 = 64'(signed'(b));
        return sa64 * sb64;
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFFFFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        q = sq;
        r = sr;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 1'b0; m_valid = 1'b0; m_hi = '0; m_lo = '0;
    end else if (flush) begin
      m_busy = 1'b0; m_valid = 1'b0;
    end else if (m_busy) begin
      m_valid = 1'b0;
      if (m_left == 1) begin
        m_hi = p_hi; m_lo = p_lo; m_valid = 1'b1; m_busy = 1'b0;
      end else begin
        m_left--;
      end
    end else begin
      m_valid = 1'b0;
      if (start) begin
        {p_hi, p_lo} = model(is_div, is_signed, op_a, op_b);
        m_busy = 1'b1;
        m_left = 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 64'(stall), 64'(m_busy ? !flush : (start && !flush)));
      chk("valid", 64'(valid), 64'(m_valid));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Issues one operation and holds start until the valid cycle, as a stalled pipeline would.
  task automatic do_op(input string nm, input bit d, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc = 0;
    int nstall = 0;
    bit got = 1'b0;
    is_div = d; is_signed = s; op_a = a; op_b = b; start = 1'b1;
    while (!got && cyc < 60) begin
      @(negedge clk);
      if (stall) nstall++;
      @(posedge clk); #2;
      cyc++;
      if (valid) got = 1'b1;
    end
    start = 1'b0;
    chk({nm, "_done"}, 64'(got), 64'd1);
    chk({nm, "_stalls"}, 64'(nstall), 64'd34);
    chk({nm, "_model"}, model(d, s, a, b), {eh, el});
    chk({nm, "_hilo"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    int nvalid;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; is_div = 1'b0; is_signed = 1'b0;
    op_a = '0; op_b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #2;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);

    do_op("multu_7x3", 1'b0, 1'b0, 32'd7, 32'd3, 32'd0, 32'h15);
    do_op("mult_neg6x7", 1'b0, 1'b1, 32'hFFFFFFFA, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFD6);
    do_op("multu_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op("div_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_ovf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    do_op("div_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    do_op("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    do_op("divu_5_0", 1'b1, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    do_op("div_m5_0", 1'b1, 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'd1);
    @(posedge clk); #2;

    // flush in the 10th BUSY cycle
    is_div = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    flush = 1'b1;
    @(negedge clk); #1;
    chk("flush_busy_stall", 64'(stall), 64'd0);
    @(posedge clk); #2;
    flush = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      if (valid) nvalid++;
    end
    chk("flush_busy_novalid", 64'(nvalid), 64'd0);
    chk("flush_busy_hilo", {hi, lo}, {32'hFFFFFFFB, 32'd1});
    do_op("after_flush", 1'b0, 1'b1, 32'd6, 32'd7, 32'd0, 32'd42);
    @(posedge clk); #2;

    // flush while in DONE: the result is dropped
    is_div = 1'b0; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #2;
    repeat (32) @(posedge clk);
    #2;
    start = 1'b0;
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (valid) nvalid++;
    end
    chk("flush_done_novalid", 64'(nvalid), 64'd0);
    chk("flush_done_hilo", {hi, lo}, {32'd0, 32'd42});

    // start toggling with new operands while BUSY must not re-latch
    is_div = 1'b0; is_signed = 1'b0; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 20; i++) begin
      op_a = $urandom; op_b = $urandom; is_div = i[0]; is_signed = i[1];
      start = ~start;
      @(posedge clk); #2;
    end
    start = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40 && nvalid == 0; i++) begin
      @(posedge clk); #2;
      if (valid) nvalid++;
    end
    chk("toggle_valid", 64'(nvalid), 64'd1);
    chk("toggle_hilo", {hi, lo}, {32'd0, 32'd30});

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
